// File: rtl/mips_mem_pkg.sv
// Shared encodings for the multicycle MIPS memory-access path.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane steering: narrows rt to the access size,
// replicates it across byte lanes and flags misaligned/reserved accesses.
module store_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o
);

  // Size/offset decode into replicated data, byte enables and alignment fault
  always_comb begin
    wdata_o      = '0;
    be_o         = BE_NONE;
    misaligned_o = 1'b0;
    case (size_e'(size_i))
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = BE_BYTE << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o      = {2{data_i[15:0]}};
        be_o         = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        misaligned_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        wdata_o      = data_i;
        be_o         = BE_WORD;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Store-path unit: aligns/narrows rt and performs one registered memory
// write over a req/ack handshake with an ack-timeout watchdog.
module store_narrow
  import mips_mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic [31:0] o_bad_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          aerr_q, aerr_d;
  logic          berr_q, berr_d;
  logic          we_q, we_d;
  logic [31:0]   bad_q, bad_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis;

  store_lane_align u_align (
    .size_i       (i_size),
    .addr_lo_i    (i_addr[1:0]),
    .data_i       (i_data),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .misaligned_o (al_mis)
  );

  // Next-state and next-output decode; outputs are registered from these
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    bad_d   = bad_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ST_WRITE: begin
        if (i_mem_ack) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LIM) begin
          state_d = ST_ERR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (i_start) begin
          if (al_mis) begin
            state_d = ST_ERR;
            aerr_d  = 1'b1;
            bad_d   = i_addr;
          end else begin
            state_d = ST_WRITE;
            cnt_d   = '0;
            maddr_d = {i_addr[31:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
          end
        end
      end
    endcase
    we_d = (state_d == ST_WRITE);
    // Enables are only meaningful while a write is requested
    if (!we_d) be_d = BE_NONE;
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      we_q    <= 1'b0;
      bad_q   <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign o_busy      = we_q;
  assign o_mem_we    = we_q;
  assign o_done      = done_q;
  assign o_addr_err  = aerr_q;
  assign o_bus_err   = berr_q;
  assign o_bad_addr  = bad_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed, table-driven bench for store_narrow.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_mem_ack;
  logic        o_busy, o_done, o_addr_err, o_bus_err, o_mem_we;
  logic [31:0] o_bad_addr, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_narrow #(.ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_size      (i_size),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_mem_ack   (i_mem_ack),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_addr_err  (o_addr_err),
    .o_bus_err   (o_bus_err),
    .o_bad_addr  (o_bad_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_cyc;   // cycle in which ack is held high, 0 = never
    int          we_n;      // expected number of cycles with we high
    int          done_c;    // expected cycle of done pulse, 0 = none
    int          aerr_c;
    int          berr_c;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;        // expected be in cycle 1
    logic [31:0] bad;       // expected o_bad_addr after the operation
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and observe 20 cycles; cycle k is the k-th cycle after
  // the edge that samples the start.
  task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input int ack_cyc, output int we_n, output int done_c,
                        output int aerr_c, output int berr_c, output logic [31:0] wd1,
                        output logic [31:0] ma1, output logic [3:0] be1, output int glitch);
    we_n = 0; done_c = 0; aerr_c = 0; berr_c = 0; glitch = 0;
    i_size = sz; i_addr = a; i_data = d; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_addr = '0; i_data = '0; i_size = 2'b00;
    wd1 = o_mem_wdata; ma1 = o_mem_addr; be1 = o_mem_be;
    for (int k = 1; k <= 20; k++) begin
      if (o_mem_we) begin
        we_n++;
        if (o_mem_wdata !== wd1 || o_mem_addr !== ma1 || o_mem_be !== be1) glitch++;
      end
      if (o_busy !== o_mem_we) glitch++;
      if (32'(o_done) + 32'(o_addr_err) + 32'(o_bus_err) > 1) glitch++;
      if (o_done)     begin if (done_c == 0) done_c = k; else glitch++; end
      if (o_addr_err) begin if (aerr_c == 0) aerr_c = k; else glitch++; end
      if (o_bus_err)  begin if (berr_c == 0) berr_c = k; else glitch++; end
      i_mem_ack = (k == ack_cyc);
      tick();
    end
    i_mem_ack = 1'b0;
  endtask

  initial begin
    int we_n, done_c, aerr_c, berr_c, glitch, done_seen;
    logic [31:0] wd1, ma1;
    logic [3:0]  be1;

    //          size   addr          data          ack we done aerr berr maddr         wdata         be       bad
    vec[0] = '{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 2,  2, 3,   0,   0,  32'h0000_1000, 32'hDDDD_DDDD, 4'b1000, 32'h0};
    vec[1] = '{2'b01, 32'h0000_2002, 32'h1234_5678, 1,  1, 2,   0,   0,  32'h0000_2000, 32'h5678_5678, 4'b1100, 32'h0};
    vec[2] = '{2'b10, 32'h0000_3001, 32'h1111_2222, 0,  0, 0,   1,   0,  32'h0,         32'h0,         4'b0000, 32'h0000_3001};
    vec[3] = '{2'b11, 32'h0000_3000, 32'h3333_4444, 0,  0, 0,   1,   0,  32'h0,         32'h0,         4'b0000, 32'h0000_3000};
    vec[4] = '{2'b10, 32'h0000_4000, 32'hCAFE_F00D, 0, 15, 0,   0,  16,  32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 32'h0000_3000};
    vec[5] = '{2'b10, 32'h0000_4000, 32'hCAFE_F00D, 15,15, 16,  0,   0,  32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 32'h0000_3000};
    vec[6] = '{2'b01, 32'h0000_2001, 32'h5555_6666, 0,  0, 0,   1,   0,  32'h0,         32'h0,         4'b0000, 32'h0000_2001};
    vec[7] = '{2'b00, 32'h0000_5000, 32'h0000_00A5, 1,  1, 2,   0,   0,  32'h0000_5000, 32'hA5A5_A5A5, 4'b0001, 32'h0000_2001};
    vec[8] = '{2'b01, 32'h0000_6000, 32'hFFFF_1234, 3,  3, 4,   0,   0,  32'h0000_6000, 32'h1234_1234, 4'b0011, 32'h0000_2001};
    vec[9] = '{2'b00, 32'h0000_7002, 32'h1122_3344, 1,  1, 2,   0,   0,  32'h0000_7000, 32'h4444_4444, 4'b0100, 32'h0000_2001};

    rst = 1'b1; i_start = 1'b0; i_size = '0; i_addr = '0; i_data = '0; i_mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    chk("reset we",    32'(o_mem_we),   32'd0);
    chk("reset busy",  32'(o_busy),     32'd0);
    chk("reset pulses", {29'd0, o_done, o_addr_err, o_bus_err}, 32'd0);
    chk("reset bad",   o_bad_addr,      32'd0);
    chk("reset maddr", o_mem_addr,      32'd0);
    chk("reset wdata", o_mem_wdata,     32'd0);
    chk("reset be",    32'(o_mem_be),   32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vec[i].size, vec[i].addr, vec[i].data, vec[i].ack_cyc,
             we_n, done_c, aerr_c, berr_c, wd1, ma1, be1, glitch);
      chk($sformatf("v%0d we_cycles", i), 32'(we_n),   32'(vec[i].we_n));
      chk($sformatf("v%0d done_cyc", i),  32'(done_c), 32'(vec[i].done_c));
      chk($sformatf("v%0d aerr_cyc", i),  32'(aerr_c), 32'(vec[i].aerr_c));
      chk($sformatf("v%0d berr_cyc", i),  32'(berr_c), 32'(vec[i].berr_c));
      chk($sformatf("v%0d be", i),        32'(be1),    32'(vec[i].be));
      chk($sformatf("v%0d bad_addr", i),  o_bad_addr,  vec[i].bad);
      chk($sformatf("v%0d glitches", i),  32'(glitch), 32'd0);
      if (vec[i].we_n > 0) begin
        chk($sformatf("v%0d mem_addr", i), ma1, vec[i].maddr);
        chk($sformatf("v%0d wdata", i),    wd1, vec[i].wdata);
      end
    end

    // Reset during WRITE: outputs drop asynchronously, late ack gives no done
    i_size = 2'b10; i_addr = 32'h0000_8000; i_data = 32'h0BAD_CAFE; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("rstw we cyc1", 32'(o_mem_we), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw we",    32'(o_mem_we),  32'd0);
    chk("rstw busy",  32'(o_busy),    32'd0);
    chk("rstw be",    32'(o_mem_be),  32'd0);
    chk("rstw maddr", o_mem_addr,     32'd0);
    chk("rstw bad",   o_bad_addr,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_done || o_mem_we || o_bus_err) done_seen++;
      tick();
    end
    chk("rstw no done", 32'(done_seen), 32'd0);

    // Back-to-back: new start in the DONE cycle
    i_size = 2'b10; i_addr = 32'h0000_9000; i_data = 32'h0102_0304; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_mem_ack = 1'b1;        // cycle 1
    tick();
    i_mem_ack = 1'b0;                        // cycle 2
    chk("b2b done", 32'(o_done), 32'd1);
    i_size = 2'b01; i_addr = 32'h0000_A002; i_data = 32'h0000_BEEF; i_start = 1'b1;
    tick();                                  // cycle 3
    i_start = 1'b0;
    chk("b2b we2",    32'(o_mem_we), 32'd1);
    chk("b2b addr2",  o_mem_addr,    32'h0000_A000);
    chk("b2b wdata2", o_mem_wdata,   32'hBEEF_BEEF);
    chk("b2b be2",    32'(o_mem_be), 32'hC);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk("b2b done2", 32'(o_done), 32'd1);
    tick();

    // Start during WRITE is ignored
    i_size = 2'b10; i_addr = 32'h0000_B000; i_data = 32'h0506_0708; i_start = 1'b1;
    tick();                                  // cycle 1
    i_size = 2'b00; i_addr = 32'h0000_C001; i_data = 32'h0000_00FF;
    tick();                                  // cycle 2
    i_start = 1'b0;
    chk("ign we",    32'(o_mem_we), 32'd1);
    chk("ign addr",  o_mem_addr,    32'h0000_B000);
    chk("ign wdata", o_mem_wdata,   32'h0506_0708);
    chk("ign be",    32'(o_mem_be), 32'hF);
    i_mem_ack = 1'b1;
    tick();                                  // cycle 3
    i_mem_ack = 1'b0;
    chk("ign done", 32'(o_done), 32'd1);
    tick();                                  // cycle 4
    chk("ign no second we", 32'(o_mem_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
